// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Results are computed at issue and committed when the busy countdown expires.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] MUL_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   hi_d, lo_d;
  logic [31:0]   pend_hi, pend_hi_d;
  logic [31:0]   pend_lo, pend_lo_d;
  logic          pend_ok, pend_ok_d;

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mthi, is_mtlo;

  assign is_mult  = (op == 3'd1);
  assign is_multu = (op == 3'd2);
  assign is_div   = (op == 3'd3);
  assign is_divu  = (op == 3'd4);
  assign is_mthi  = (op == 3'd5);
  assign is_mtlo  = (op == 3'd6);

  // Sign-extended operands give the signed product in the low 64 bits.
  logic [63:0] prod_s, prod_u;
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};
  assign prod_s = {{32{rs_data[31]}}, rs_data}
                * {{32{rt_data[31]}}, rt_data};

  logic        div_zero;
  logic [31:0] uq, ur;
  logic [31:0] a_mag, b_mag;
  logic [31:0] mq, mr;
  logic [31:0] sq, sr;

  assign div_zero = (rt_data == 32'd0);
  assign uq = div_zero ? 32'd0 : rs_data / rt_data;
  assign ur = div_zero ? 32'd0 : rs_data % rt_data;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign a_mag = rs_data[31] ? (32'd0 - rs_data) : rs_data;
  assign b_mag = rt_data[31] ? (32'd0 - rt_data) : rt_data;
  assign mq = div_zero ? 32'd0 : a_mag / b_mag;
  assign mr = div_zero ? 32'd0 : a_mag % b_mag;
  assign sq = (rs_data[31] ^ rt_data[31]) ? (32'd0 - mq) : mq;
  assign sr = rs_data[31] ? (32'd0 - mr) : mr;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hi_d      = hi;
    lo_d      = lo;
    pend_hi_d = pend_hi;
    pend_lo_d = pend_lo;
    pend_ok_d = pend_ok;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mult: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_ok_d = 1'b1;
              cnt_d     = MUL_LAT;
              state_d   = RUN;
            end
            is_multu: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_ok_d = 1'b1;
              cnt_d     = MUL_LAT;
              state_d   = RUN;
            end
            is_div: begin
              pend_hi_d = sr;
              pend_lo_d = sq;
              pend_ok_d = !div_zero;
              cnt_d     = DIV_LAT;
              state_d   = RUN;
            end
            is_divu: begin
              pend_hi_d = ur;
              pend_lo_d = uq;
              pend_ok_d = !div_zero;
              cnt_d     = DIV_LAT;
              state_d   = RUN;
            end
            is_mthi: hi_d = rs_data;
            is_mtlo: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt - ONE;
        if (cnt == ONE) begin
          state_d   = IDLE;
          pend_ok_d = 1'b0;
          if (pend_ok) begin
            hi_d = pend_hi;
            lo_d = pend_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      hi      <= hi_d;
      lo      <= lo_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
      pend_ok <= pend_ok_d;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, HI/LO results,
// ignored requests while busy, divide by zero and reset abort.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s_hi", tag), hi, m_hi);
    chk($sformatf("%s_lo", tag), lo, m_lo);
  endtask

  // Issue one op, check busy and held HI/LO each run cycle,
  // optionally inject a second request at cycle inj_cyc.
  task automatic run_op(input string tag,
                        input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int lat,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input int inj_cyc,
                        input logic [2:0] inj_op);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    tick();
    start = 1'b0; op = 3'd0;
    for (int c = 1; c <= lat; c++) begin
      if (c == inj_cyc) begin
        start = 1'b1; op = inj_op;
        rs_data = 32'hDEAD_BEEF; rt_data = 32'h3;
      end
      chk($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_hold_hi_c%0d", tag, c), hi, m_hi);
      chk($sformatf("%s_hold_lo_c%0d", tag, c), lo, m_lo);
      tick();
      start = 1'b0; op = 3'd0;
    end
    m_hi = eh;
    m_lo = el;
    idle_chk($sformatf("%s_done", tag));
  endtask

  task automatic move(input string tag, input logic [2:0] o,
                      input logic [31:0] v);
    start = 1'b1; op = o; rs_data = v; rt_data = 32'h0;
    tick();
    start = 1'b0; op = 3'd0;
    if (o == 3'd5) m_hi = v;
    if (o == 3'd6) m_lo = v;
    idle_chk(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0;
    rs_data = 32'h0; rt_data = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    tick(); tick();
    reset = 1'b0;
    idle_chk("reset");

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFF, 32'h3, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 3'd0);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
           32'hFFFF_FFFE, 32'h0000_0001, 0, 3'd0);
    run_op("mult_minsq", 3'd1, 32'h8000_0000, 32'h8000_0000, 5,
           32'h4000_0000, 32'h0000_0000, 0, 3'd0);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 3'd0);
    run_op("divu_big", 3'd4, 32'hFFFF_FFF9, 32'h2, 10,
           32'h0000_0001, 32'h7FFF_FFFC, 0, 3'd0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'h0000_0000, 32'h8000_0000, 0, 3'd0);
    run_op("div_mix", 3'd3, 32'd100, 32'hFFFF_FFF9, 10,
           32'h0000_0002, 32'hFFFF_FFF2, 0, 3'd0);

    move("mthi_11", 3'd5, 32'h11);
    move("mtlo_22", 3'd6, 32'h22);
    run_op("divu_zero", 3'd4, 32'd5, 32'd0, 10,
           32'h11, 32'h22, 0, 3'd0);

    move("mthi_abcd", 3'd5, 32'hABCD_0000);

    start = 1'b1; op = 3'd7; rs_data = 32'h1234; rt_data = 32'h1;
    tick();
    start = 1'b0; op = 3'd0;
    idle_chk("op7_none");
    start = 1'b0; op = 3'd5; rs_data = 32'h5555;
    tick();
    op = 3'd0;
    idle_chk("nostart");

    run_op("mult_mtlo_ign", 3'd1, 32'd7, 32'd6, 5,
           32'h0, 32'd42, 2, 3'd6);
    run_op("mult_b2b", 3'd1, 32'd3, 32'd4, 5,
           32'h0, 32'd12, 5, 3'd1);
    run_op("mult_reissue", 3'd1, 32'd5, 32'd5, 5,
           32'h0, 32'd25, 0, 3'd0);

    start = 1'b1; op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    tick();
    start = 1'b0; op = 3'd0;
    tick(); tick();
    chk("rst_abort_busy_c3", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    idle_chk("rst_abort");
    for (int i = 0; i < 12; i++) tick();
    idle_chk("rst_nocommit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
